// File: rtl/instr_fetch_arbiter.sv
// rtl/instr_fetch_arbiter.sv - round-robin instruction fetch arbiter over one combinational instruction memory
// Grant and memory address are combinational; the instruction returns on a registered bus one cycle later.
module instr_fetch_arbiter #(
    parameter int N_CPU  = 3,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    localparam int SEL_W = $clog2(N_CPU)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CPU-1:0]          cpu_req,
    input  logic [N_CPU*ADDR_W-1:0]   cpu_addr,
    output logic [N_CPU-1:0]          cpu_ack,
    output logic [N_CPU-1:0]          cpu_rvalid,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic [SEL_W-1:0]          grant_cnt_sel,
    output logic [15:0]               grant_cnt
);

    logic [SEL_W-1:0]  last_grant_q, last_grant_d;
    logic [N_CPU-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [15:0]       cnt_q [N_CPU];
    logic [15:0]       cnt_d [N_CPU];

    logic              win_valid;
    logic [SEL_W-1:0]  win_idx;
    logic [SEL_W:0]    sum;
    logic [SEL_W-1:0]  cand;

    // Scan offsets from farthest to nearest so the nearest requester after last_grant overwrites the rest.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int off = N_CPU; off >= 1; off--) begin
            sum  = {1'b0, last_grant_q} + (SEL_W+1)'(off);
            cand = (sum >= (SEL_W+1)'(N_CPU)) ? SEL_W'(sum - (SEL_W+1)'(N_CPU)) : SEL_W'(sum);
            if (cpu_req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        cpu_ack  = '0;
        mem_addr = '0;
        if (win_valid) begin
            cpu_ack[win_idx] = 1'b1;
            mem_addr         = cpu_addr[win_idx*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        last_grant_d = win_valid ? win_idx : last_grant_q;
        rvalid_d     = cpu_ack;
        rdata_d      = win_valid ? mem_rdata : rdata_q;
        for (int i = 0; i < N_CPU; i++) begin
            cnt_d[i] = (cpu_ack[i] && cnt_q[i] != 16'hFFFF) ? cnt_q[i] + 16'd1 : cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= SEL_W'(N_CPU - 1);
            rvalid_q     <= '0;
            rdata_q      <= '0;
            for (int i = 0; i < N_CPU; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            for (int i = 0; i < N_CPU; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = rdata_q;

    // Selects that match no CPU fall through to zero.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_CPU; i++) begin
            if (grant_cnt_sel == SEL_W'(i)) begin
                grant_cnt = cnt_q[i];
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_arbiter.sv
// tb/tb_instr_fetch_arbiter.sv - table-driven and scoreboarded bench for instr_fetch_arbiter
module tb_instr_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  cpu_req;
    logic [17:0] cpu_addr;
    logic [2:0]  cpu_ack;
    logic [2:0]  cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic [5:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [1:0]  grant_cnt_sel;
    logic [15:0] grant_cnt;

    instr_fetch_arbiter #(.N_CPU(3), .ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .grant_cnt_sel(grant_cnt_sel), .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    assign mem_rdata = mem[mem_addr];

    typedef struct {
        logic [2:0] req;
        logic [5:0] a0, a1, a2;
        logic [2:0] ack;
        logic [5:0] maddr;
    } vec_t;

    typedef struct {
        logic [2:0]  rvalid;
        logic [31:0] rdata;
    } resp_t;

    resp_t       sb[$];
    vec_t        tbl[13];
    logic [31:0] model_rdata;
    int          gcount[3];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic [2:0] req, input logic [5:0] a0, input logic [5:0] a1,
                         input logic [5:0] a2, input logic [2:0] eack, input logic [5:0] emaddr);
        resp_t r;
        @(posedge clk);
        #2;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty: got 0 entries required 1");
        end else begin
            r = sb.pop_front();
            check("rvalid", 32'(cpu_rvalid), 32'(r.rvalid));
            check("rdata", cpu_rdata, r.rdata);
        end
        cpu_req  = req;
        cpu_addr = {a2, a1, a0};
        #1;
        check("ack", 32'(cpu_ack), 32'(eack));
        check("mem_addr", 32'(mem_addr), 32'(emaddr));
        if (eack != 3'b000) begin
            model_rdata = mem[emaddr];
            for (int i = 0; i < 3; i++) if (eack[i]) gcount[i]++;
        end
        r.rvalid = eack;
        r.rdata  = model_rdata;
        sb.push_back(r);
    endtask

    // Reset is applied mid-cycle; ack/mem_addr must still track requests while no grant is recorded.
    task automatic do_reset();
        resp_t r;
        rst_n   = 1'b0;
        cpu_req = 3'b000;
        #1;
        check("reset_rvalid", 32'(cpu_rvalid), 32'd0);
        check("reset_rdata", cpu_rdata, 32'd0);
        cpu_req  = 3'b010;
        cpu_addr = {6'd0, 6'd9, 6'd0};
        #1;
        check("reset_ack", 32'(cpu_ack), 32'b010);
        check("reset_mem_addr", 32'(mem_addr), 32'd9);
        repeat (2) @(posedge clk);
        #2;
        cpu_req  = 3'b000;
        cpu_addr = '0;
        #2;
        rst_n = 1'b1;
        sb.delete();
        model_rdata = '0;
        for (int i = 0; i < 3; i++) gcount[i] = 0;
        r.rvalid = 3'b000;
        r.rdata  = 32'd0;
        sb.push_back(r);
    endtask

    initial begin
        resp_t r;
        logic [2:0] e;
        for (int i = 0; i < 64; i++) mem[i] = {8'(i), 8'hC3, 8'(~i), 8'(i * 7)};
        mem[5]        = 32'h00500093;
        rst_n         = 1'b0;
        cpu_req       = '0;
        cpu_addr      = '0;
        grant_cnt_sel = '0;

        tbl[0]  = '{3'b010, 6'd0,  6'd5,  6'd0,  3'b010, 6'd5};
        tbl[1]  = '{3'b000, 6'd0,  6'd0,  6'd0,  3'b000, 6'd0};
        tbl[2]  = '{3'b111, 6'd10, 6'd11, 6'd12, 3'b100, 6'd12};
        tbl[3]  = '{3'b111, 6'd10, 6'd11, 6'd12, 3'b001, 6'd10};
        tbl[4]  = '{3'b101, 6'd20, 6'd0,  6'd21, 3'b100, 6'd21};
        tbl[5]  = '{3'b001, 6'd20, 6'd0,  6'd0,  3'b001, 6'd20};
        tbl[6]  = '{3'b111, 6'd30, 6'd31, 6'd32, 3'b010, 6'd31};
        tbl[7]  = '{3'b111, 6'd30, 6'd31, 6'd32, 3'b100, 6'd32};
        tbl[8]  = '{3'b111, 6'd30, 6'd31, 6'd32, 3'b001, 6'd30};
        tbl[9]  = '{3'b100, 6'd0,  6'd0,  6'd63, 3'b100, 6'd63};
        tbl[10] = '{3'b011, 6'd0,  6'd1,  6'd0,  3'b001, 6'd0};
        tbl[11] = '{3'b000, 6'd0,  6'd0,  6'd0,  3'b000, 6'd0};
        tbl[12] = '{3'b110, 6'd0,  6'd7,  6'd8,  3'b010, 6'd7};

        #3;
        do_reset();
        for (int k = 0; k < 13; k++)
            cycle(tbl[k].req, tbl[k].a0, tbl[k].a1, tbl[k].a2, tbl[k].ack, tbl[k].maddr);
        cycle(3'b000, 6'd0, 6'd0, 6'd0, 3'b000, 6'd0);
        for (int i = 0; i < 4; i++) begin
            grant_cnt_sel = 2'(i);
            #1;
            check("grant_cnt", 32'(grant_cnt), (i < 3) ? 32'(gcount[i]) : 32'd0);
        end

        // Continuous requests from reset rotate 0,1,2,0,1,2.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            e = 3'b001 << (k % 3);
            cycle(3'b111, 6'd40, 6'd41, 6'd42, e, 6'(40 + k % 3));
        end
        cycle(3'b000, 6'd0, 6'd0, 6'd0, 3'b000, 6'd0);

        // Reset lands while a response is on the bus; it must vanish and never reappear.
        cycle(3'b010, 6'd0, 6'd5, 6'd0, 3'b010, 6'd5);
        @(posedge clk);
        #2;
        r = sb.pop_front();
        check("pre_reset_rvalid", 32'(cpu_rvalid), 32'(r.rvalid));
        check("pre_reset_rdata", cpu_rdata, r.rdata);
        cpu_req = 3'b000;
        do_reset();
        cycle(3'b000, 6'd0, 6'd0, 6'd0, 3'b000, 6'd0);
        cycle(3'b000, 6'd0, 6'd0, 6'd0, 3'b000, 6'd0);
        grant_cnt_sel = 2'd1;
        #1;
        check("grant_cnt_after_reset", 32'(grant_cnt), 32'd0);

        // Saturation of CPU0's grant counter.
        do_reset();
        @(posedge clk);
        #2;
        cpu_req  = 3'b001;
        cpu_addr = '0;
        repeat (65540) @(posedge clk);
        #2;
        cpu_req       = 3'b000;
        grant_cnt_sel = 2'd0;
        #1;
        check("grant_cnt_saturate", 32'(grant_cnt), 32'h0000FFFF);
        grant_cnt_sel = 2'd1;
        #1;
        check("grant_cnt_cpu1", 32'(grant_cnt), 32'd0);
        grant_cnt_sel = 2'd3;
        #1;
        check("grant_cnt_out_of_range", 32'(grant_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_arbiter.md
INSTR_FETCH_ARBITER -- requirements
Module: instr_fetch_arbiter

Interface
REQ-001 Parameter N_CPU, default 3: number of requesting CPU fetch ports, legal range 2..8.
REQ-002 Parameter ADDR_W, default 6: instruction word address width; matches the instruction memory depth of 64 words.
REQ-003 Parameter DATA_W, default 32: instruction width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cpu_req  input  N_CPU  per-CPU fetch request; bit i belongs to CPU i.
REQ-007 cpu_addr  input  N_CPU*ADDR_W  per-CPU word address; CPU i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 cpu_ack  output  N_CPU  one-hot or zero; bit i high = CPU i request accepted this cycle.
REQ-009 cpu_rvalid  output  N_CPU  one-hot or zero; bit i high = cpu_rdata holds CPU i's instruction.
REQ-010 cpu_rdata  output  DATA_W  shared, registered instruction return bus.
REQ-011 mem_addr  output  ADDR_W  address driven to the combinational instruction memory.
REQ-012 mem_rdata  input  DATA_W  instruction returned combinationally by memory for mem_addr.
REQ-013 grant_cnt_sel  input  $clog2(N_CPU)  selects which per-CPU grant counter appears on grant_cnt.
REQ-014 grant_cnt  output  16  saturating count of grants to the selected CPU.

Function
REQ-015 Arbitration is combinational within a cycle: the winner is the first requesting CPU, searching upward from index (last_grant+1) mod N_CPU with wrap-around.
REQ-016 After reset, last_grant = N_CPU-1, so CPU 0 has highest priority on the first arbitration.
REQ-017 When at least one cpu_req bit is high, the winner's cpu_ack bit is high and mem_addr equals the winner's cpu_addr, both in the same cycle.
REQ-018 When no cpu_req bit is high, cpu_ack = 0, mem_addr = 0, and last_grant is unchanged.
REQ-019 At most one grant per cycle; last_grant is updated to the winner on the edge ending a grant cycle.
REQ-020 On the edge ending grant cycle T, mem_rdata is captured into cpu_rdata and the winner's cpu_rvalid bit is set, so read latency is exactly 1 cycle and cpu_rvalid is high only during cycle T+1.
REQ-021 If no grant occurs in cycle T, cpu_rvalid = 0 in cycle T+1 and cpu_rdata holds its previous value.
REQ-022 Requests may be granted back-to-back every cycle; full throughput is 1 instruction per cycle.
REQ-023 A CPU holds cpu_req and cpu_addr stable until it sees cpu_ack; it may issue the next request in the cycle after ack.
REQ-024 A request withdrawn before ack is dropped without error; no state retains it.
REQ-025 Fairness: any continuously asserted request is acked within N_CPU cycles.
REQ-026 A CPU may hold a new request in the same cycle its previous rvalid is high; the two are independent.
REQ-027 Each per-CPU 16-bit grant counter increments on that CPU's grant and saturates at 0xFFFF.
REQ-028 grant_cnt is a combinational mux of the counters by grant_cnt_sel; an out-of-range select reads 0.

Reset
REQ-029 On rst_n low, immediately and independently of clk: cpu_rvalid = 0, cpu_rdata = 0, last_grant = N_CPU-1, and all grant counters = 0.
REQ-030 During reset, cpu_ack and mem_addr still follow REQ-015..018 combinationally, but no grant is recorded.
REQ-031 Reset asserted mid-transfer discards the in-flight response; no rvalid is issued for it after release.
REQ-032 The first rising edge with rst_n high resumes normal operation.

Verification
REQ-033 Single requester: CPU1 requests addr 5 with memory word 5 = 0x00500093 -> cpu_ack = 3'b010 in cycle T; cpu_rvalid = 3'b010 and cpu_rdata = 0x00500093 in T+1.
REQ-034 All three CPUs request continuously from reset -> ack order 0,1,2,0,1,2 on consecutive cycles, with rvalid following one cycle later.
REQ-035 CPU0 and CPU2 request while last_grant = 0 -> CPU2 wins; next cycle CPU0 wins.
REQ-036 Idle cycle between requests -> cpu_ack = 0, mem_addr = 0, no rvalid on the next cycle, cpu_rdata unchanged.
REQ-037 Assert rst_n low in the cycle after a grant, before the clock edge -> cpu_rvalid = 0 immediately and no stale rvalid after release.
REQ-038 Force 65540 grants to CPU0 -> grant_cnt with grant_cnt_sel = 0 reads 0xFFFF and does not wrap.
